// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_add_pkg
// Purpose : Shared types and limits for the bit-serial add sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package serial_add_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Legal operand widths
   localparam int MIN_WIDTH = 2;
   localparam int MAX_WIDTH = 64;

endpackage : serial_add_pkg
`default_nettype wire

// File: rtl/serial_fa_bit.sv
`default_nettype none
// ============================================================================
// Module  : serial_fa_bit
// Purpose : One-bit full-add cell built from two half-add stages; the single
//           shared arithmetic resource of the serial sequencer.
// Rev     : 1.0  initial release
// ============================================================================
module serial_fa_bit (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic w_s1;
   logic w_c1;
   logic w_c2;

   // First half-add stage: operand bits
   assign w_s1 = a ^ b;
   assign w_c1 = a & b;

   // Second half-add stage: partial sum with incoming carry
   assign s    = w_s1 ^ ci;
   assign w_c2 = w_s1 & ci;

   // Either stage may generate the carry
   assign co   = w_c1 | w_c2;

endmodule : serial_fa_bit
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : serial_add_ctrl
// Purpose : Bit-serial adder sequencer. Adds two WIDTH-bit operands plus
//           carry-in one bit per clock, LSB first, through a single full-add
//           cell, with valid/ready handshakes on both sides.
//           Optional macro SERIAL_ADD_OVF_EN adds the signed-overflow port.
// Rev     : 1.0  initial release
// ============================================================================
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   // Counter is one bit wider than the index range so it never wraps
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

   state_t             r_state;
   logic [WIDTH-1:0]   r_a_sr;
   logic [WIDTH-1:0]   r_b_sr;
   logic [WIDTH-1:0]   r_sum_sr;
   logic               r_carry;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_out_valid;
   logic               r_busy;
   logic               r_cout;
`ifdef SERIAL_ADD_OVF_EN
   logic               r_ovf;
`endif

   logic               w_s;
   logic               w_co;

   // The one shared full-add cell, fed from the shift-register LSBs
   serial_fa_bit u_fa (
      .a  (r_a_sr[0]),
      .b  (r_b_sr[0]),
      .ci (r_carry),
      .s  (w_s),
      .co (w_co)
   );

   // Sequencer FSM with datapath shift registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_a_sr      <= '0;
         r_b_sr      <= '0;
         r_sum_sr    <= '0;
         r_carry     <= 1'b0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_cout      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         r_ovf       <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a_sr  <= a;
                  r_b_sr  <= b;
                  r_carry <= cin;
                  r_cnt   <= '0;
                  r_cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
                  r_ovf   <= 1'b0;
`endif
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_a_sr   <= r_a_sr >> 1;
               r_b_sr   <= r_b_sr >> 1;
               r_sum_sr <= {w_s, r_sum_sr[WIDTH-1:1]};
               r_carry  <= w_co;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == C_LAST) begin
                  r_cout      <= w_co;
`ifdef SERIAL_ADD_OVF_EN
                  // Carry into the MSB differs from carry out of it
                  r_ovf       <= r_carry ^ w_co;
`endif
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   // in_ready is decoded from the state register only
   assign in_ready  = (r_state == IDLE);
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign sum       = r_sum_sr;
   assign cout      = r_cout;
`ifdef SERIAL_ADD_OVF_EN
   assign ovf       = r_ovf;
`endif

endmodule : serial_add_ctrl
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_add_ctrl
// Purpose : Directed self-checking bench for serial_add_ctrl (WIDTH=8).
// Rev     : 1.0  initial release
// ============================================================================
module tb_serial_add_ctrl;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] sum;
   logic       cout;
   logic       busy;
`ifdef SERIAL_ADD_OVF_EN
   logic       ovf;
`endif

   int n_checks = 0;
   int n_errors = 0;

   serial_add_ctrl #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Wait (bounded) for out_valid; returns number of clock edges waited
   task automatic wait_valid(output int k);
      k = 0;
      while (out_valid !== 1'b1 && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
   endtask

   // One complete add with out_ready held high
   task automatic run_add(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                          input logic op_c, input logic [7:0] esum, input logic ecout);
      int k;
      @(negedge clk);
      a = op_a; b = op_b; cin = op_c; in_valid = 1'b1; out_ready = 1'b1;
      chk({tag, "_in_ready"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({tag, "_busy"}, busy, 1);
      wait_valid(k);
      chk({tag, "_latency"}, k, 8);
      chk({tag, "_sum"}, sum, esum);
      chk({tag, "_cout"}, cout, ecout);
      @(posedge clk); #1;
      chk({tag, "_ov_drop"}, out_valid, 0);
      chk({tag, "_ir_rise"}, in_ready, 1);
   endtask

   initial begin
      int k;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
`ifdef SERIAL_ADD_OVF_EN
      chk("rst_ovf", ovf, 0);
`endif
      @(negedge clk); rst_n = 1'b1;

      // Basic and carry-ripple adds
      run_add("basic", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
      run_add("ripple1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      run_add("ripple2", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);

      // Backpressure: result held while out_ready low, no accept on handshake edge
      @(negedge clk);
      a = 8'h10; b = 8'h20; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      a = 8'hAA; b = 8'h55;              // producer keeps in_valid with new data
      wait_valid(k);
      chk("bp_latency", k, 8);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_sum_hold", sum, 8'h30);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_hs_ov", out_valid, 0);
      chk("bp_hs_busy", busy, 0);
      chk("bp_hs_ir", in_ready, 1);
      @(posedge clk); #1;                 // second operand set accepted here
      chk("bp_next_busy", busy, 1);
      in_valid = 1'b0;
      wait_valid(k);
      chk("bp_next_sum", sum, 8'hFF);
      @(posedge clk); #1;

      // Input change after accept is ignored
      @(negedge clk);
      a = 8'h0F; b = 8'h01; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      a = 8'hF0;
      wait_valid(k);
      chk("chg_sum", sum, 8'h10);
      chk("chg_cout", cout, 0);
      @(posedge clk); #1;

      // Reset mid-RUN discards the operation
      @(negedge clk);
      a = 8'h11; b = 8'h22; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_ov", out_valid, 0);
      chk("mid_rst_ir", in_ready, 1);
      chk("mid_rst_sum", sum, 0);
      chk("mid_rst_busy", busy, 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         chk("mid_rst_no_ov", out_valid, 0);
      end
      run_add("post_rst", 8'h02, 8'h03, 1'b0, 8'h05, 1'b0);

`ifdef SERIAL_ADD_OVF_EN
      run_add("ovf1", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
      chk("ovf1_ovf", ovf, 1);
      run_add("ovf2", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
      chk("ovf2_ovf", ovf, 1);
      run_add("ovf3", 8'h40, 8'h3F, 1'b0, 8'h7F, 1'b0);
      chk("ovf3_ovf", ovf, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_serial_add_ctrl
`default_nettype wire
